aes_inv_pipe_ctrl: RTL

- Flow controller for the pipelined AES inverse cipher datapath.
- Accepts ciphertext blocks over a valid/ready handshake and drives the datapath's per-stage enables `valid[0:Nr]`, advancing only stages that hold data and can move.
- Carries a tag alongside each block and presents plaintext with out_valid/out_ready backpressure.
- Arbitrates round-key changes: drains the pipeline before granting the key expander permission to update `rkey`.

---
 rtl/aes_inv_pipe_ctrl_pkg.sv | 19 +
 rtl/aes_inv_pipe_ctrl_if.sv | 31 +++
 rtl/aes_inv_pipe_ctrl_occ.sv | 85 ++++++++
 rtl/aes_inv_pipe_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/aes_inv_pipe_ctrl_pkg.sv
// Shared types and helpers for the AES inverse-cipher pipeline controller.
//   aes_ctrl_state_e : key-change arbitration states (run / drain / key change)
//   nr_of()          : number of cipher rounds for a given key length in words
package aes_inv_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_KEYCHG = 2'd2
  } aes_ctrl_state_e;

  localparam int BLOCK_W = 32'sd128;

  // Rounds for an Nk-word key: 10/12/14 for AES-128/192/256.
  function automatic int nr_of(input int nk);
    return nk + 32'sd6;
  endfunction

endpackage

// File: rtl/aes_inv_pipe_ctrl_if.sv
// Block-level handshake bundle for the inverse-cipher pipeline controller.
//   in_*        : ciphertext offer (valid/ready, block, tag)
//   out_*       : plaintext presentation (valid/ready, block, tag)
//   key_chg_*   : round-key update request/grant with the key expander
// master = traffic source/sink and key expander, slave = the controller.
interface aes_inv_pipe_ctrl_if #(
  parameter int TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_ct;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_pt;
  logic [TAG_W-1:0] out_tag;
  logic             key_chg_req;
  logic             key_chg_gnt;

  modport master (
    output in_valid, in_ct, in_tag, out_ready, key_chg_req,
    input  in_ready, out_pt, out_tag, out_valid, key_chg_gnt
  );

  modport slave (
    input  in_valid, in_ct, in_tag, out_ready, key_chg_req,
    output in_ready, out_pt, out_tag, out_valid, key_chg_gnt
  );

endinterface

// File: rtl/aes_inv_pipe_ctrl_occ.sv
// Occupancy and tag shift chain for the Nr+1 datapath stages.
// Data moves from stage Nr (input) toward stage 0 (output).
//   clk, rst   : clock, async active-high reset
//   admit      : controller allows new blocks in (RUN, no key request)
//   in_valid   : ciphertext offered; in_tag its tag
//   out_ready  : downstream accepts stage 0
//   in_ready   : input handshake ready
//   dp_en      : per-stage load enables, bit i loads stage i
//   occ        : occupancy vector, bit i = stage i holds a block
//   out_tag    : tag travelling with stage 0
module aes_inv_pipe_ctrl_occ #(
  parameter int Nr    = 10,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             admit,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             out_ready,
  output logic             in_ready,
  output logic [Nr:0]      dp_en,
  output logic [Nr:0]      occ,
  output logic [TAG_W-1:0] out_tag
);

  logic [Nr:0]      occ_r;
  logic [Nr:0]      occ_nxt_s;
  logic [Nr:0]      adv_s;
  logic [Nr:0]      en_s;
  logic             in_ready_s;
  logic             fire_out_s;
  logic [TAG_W-1:0] tag_r [0:Nr];

  // Advance chain, stage enables and next occupancy
  always_comb begin
    adv_s     = {(Nr+1){1'b0}};
    en_s      = {(Nr+1){1'b0}};
    occ_nxt_s = {(Nr+1){1'b0}};
    // A stage can take new data if it is empty or its own block moves on,
    // so bubbles ahead of a held stage still collapse.
    adv_s[0] = ~occ_r[0] | out_ready;
    for (int i = 1; i <= Nr; i++) begin
      adv_s[i] = ~occ_r[i] | adv_s[i-1];
    end
    in_ready_s = admit & adv_s[Nr];
    fire_out_s = occ_r[0] & out_ready;
    en_s[Nr]   = in_valid & in_ready_s;
    for (int i = 0; i < Nr; i++) begin
      en_s[i] = occ_r[i+1] & adv_s[i];
    end
    // A stage empties when the stage below loads its block (or, for
    // stage 0, when the output fires); a same-cycle refill keeps it full.
    occ_nxt_s[0] = en_s[0] | (occ_r[0] & ~fire_out_s);
    for (int i = 1; i <= Nr; i++) begin
      occ_nxt_s[i] = en_s[i] | (occ_r[i] & ~en_s[i-1]);
    end
  end

  // Occupancy and tag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r <= {(Nr+1){1'b0}};
      for (int i = 0; i <= Nr; i++) begin
        tag_r[i] <= {TAG_W{1'b0}};
      end
    end else begin
      occ_r <= occ_nxt_s;
      if (en_s[Nr]) begin
        tag_r[Nr] <= in_tag;
      end
      for (int i = 0; i < Nr; i++) begin
        if (en_s[i]) begin
          tag_r[i] <= tag_r[i+1];
        end
      end
    end
  end

  assign in_ready = in_ready_s;
  assign dp_en    = en_s;
  assign occ      = occ_r;
  assign out_tag  = tag_r[0];

endmodule

// File: rtl/aes_inv_pipe_ctrl.sv
// Flow controller for the pipelined AES inverse cipher datapath.
// Admits ciphertext blocks, drives the datapath stage enables, carries a tag
// per block and drains the pipeline before granting a round-key update.
//   clk, rst : clock, async active-high reset
//   bus      : handshake bundle (slave side): in_*, out_*, key_chg_*
//   dp_ct    : ciphertext to the datapath (straight from in_ct)
//   dp_pt    : plaintext from the datapath, presented on out_pt
//   dp_en    : per-stage enables to datapath valid[0:Nr]
//   busy     : any stage occupied
module aes_inv_pipe_ctrl
  import aes_inv_pipe_ctrl_pkg::*;
#(
  parameter int Nk    = 4,
  parameter int Nr    = nr_of(Nk),
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  aes_inv_pipe_ctrl_if.slave  bus,
  output logic [127:0]        dp_ct,
  input  logic [127:0]        dp_pt,
  output logic [Nr:0]         dp_en,
  output logic                busy
);

  aes_ctrl_state_e  state_r;
  logic             gnt_r;
  logic             admit_s;
  logic             in_ready_s;
  logic [Nr:0]      occ_s;
  logic [Nr:0]      en_s;
  logic [TAG_W-1:0] out_tag_s;

  // Admission gate: a pending key request wins over a same-cycle offer, and
  // nothing is admitted while reset is held.
  always_comb begin
    admit_s = ~rst & (state_r == ST_RUN) & ~bus.key_chg_req;
  end

  aes_inv_pipe_ctrl_occ #(
    .Nr    (Nr),
    .TAG_W (TAG_W)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .admit     (admit_s),
    .in_valid  (bus.in_valid),
    .in_tag    (bus.in_tag),
    .out_ready (bus.out_ready),
    .in_ready  (in_ready_s),
    .dp_en     (en_s),
    .occ       (occ_s),
    .out_tag   (out_tag_s)
  );

  // Key-change arbitration FSM with registered grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      gnt_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          gnt_r <= 1'b0;
          if (bus.key_chg_req) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Always spends at least one cycle here, even if already empty.
          if (!bus.key_chg_req) begin
            state_r <= ST_RUN;
            gnt_r   <= 1'b0;
          end else if (occ_s == {(Nr+1){1'b0}}) begin
            state_r <= ST_KEYCHG;
            gnt_r   <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
            gnt_r   <= 1'b0;
          end
        end
        ST_KEYCHG: begin
          if (!bus.key_chg_req) begin
            state_r <= ST_RUN;
            gnt_r   <= 1'b0;
          end else begin
            state_r <= ST_KEYCHG;
            gnt_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_RUN;
          gnt_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = occ_s[0];
  assign bus.out_pt      = dp_pt;
  assign bus.out_tag     = out_tag_s;
  assign bus.key_chg_gnt = gnt_r;
  assign dp_ct           = bus.in_ct;
  assign dp_en           = en_s;
  assign busy            = |occ_s;

endmodule
